// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - instruction fetch controller: PC, IR latch, valid/ack handoff, jump/halt, wrap flag
module inst_fetch_ctrl #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  addr,
    input  logic [15:0] r_data,
    output logic [15:0] ir,
    output logic        ir_valid,
    input  logic        ir_ack,
    input  logic        jump,
    input  logic [7:0]  jump_addr,
    input  logic        halt,
    output logic [7:0]  pc,
    output logic [1:0]  state,
    output logic        wrap
);

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_FETCH  = 2'b01;
    localparam logic [1:0] S_HOLD   = 2'b10;
    localparam logic [1:0] S_HALTED = 2'b11;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            ir       <= 16'h0000;
            ir_valid <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir       <= r_data;
                    ir_valid <= 1'b1;
                    state    <= S_HOLD;
                end
                S_HOLD: begin
                    // halt wins over jump so pc keeps pointing at the halting instruction
                    if (ir_ack) begin
                        ir_valid <= 1'b0;
                        if (halt) begin
                            state <= S_HALTED;
                        end else if (jump) begin
                            pc    <= jump_addr;
                            state <= S_FETCH;
                        end else begin
                            pc    <= pc + 8'd1;
                            state <= S_FETCH;
                            if (pc == 8'hFF) begin
                                wrap <= 1'b1;
                            end
                        end
                    end
                end
                S_HALTED: begin
                    ir_valid <= 1'b0;
                    if (start) begin
                        pc    <= RESET_PC;
                        wrap  <= 1'b0;
                        state <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign addr = pc;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - directed self-checking bench for inst_fetch_ctrl
module tb_inst_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  addr;
    logic [15:0] r_data;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_ack;
    logic        jump;
    logic [7:0]  jump_addr;
    logic        halt;
    logic [7:0]  pc;
    logic [1:0]  state;
    logic        wrap;

    logic [15:0] rom [0:255];
    logic        ovr_en;
    logic [15:0] ovr_val;

    int tests;
    int fails;

    assign r_data = ovr_en ? ovr_val : rom[addr];

    inst_fetch_ctrl #(.RESET_PC(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .addr      (addr),
        .r_data    (r_data),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .ir_ack    (ir_ack),
        .jump      (jump),
        .jump_addr (jump_addr),
        .halt      (halt),
        .pc        (pc),
        .state     (state),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ack in the first HOLD cycle, then let the following FETCH complete
    task automatic advance();
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (state !== 2'b00) begin fails++; $display("FAIL rst_state got %h exp 0", state); end
        tests++; if (pc !== 8'h00) begin fails++; $display("FAIL rst_pc got %h exp 00", pc); end
        tests++; if (addr !== 8'h00) begin fails++; $display("FAIL rst_addr got %h exp 00", addr); end
        tests++; if (ir !== 16'h0000) begin fails++; $display("FAIL rst_ir got %h exp 0000", ir); end
        tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", ir_valid); end
        tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL rst_wrap got %b exp 0", wrap); end
        ir_ack = 1'b1;
        tick();
        tick();
        ir_ack = 1'b0;
        tests++; if (state !== 2'b00 || pc !== 8'h00) begin fails++; $display("FAIL idle_hold got state %h pc %h exp 0/00", state, pc); end
    endtask

    task automatic test_basic_fetch();
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++; if (state !== 2'b01 || ir_valid !== 1'b0) begin fails++; $display("FAIL start_fetch got state %h valid %b exp 1/0", state, ir_valid); end
        tick();
        tests++; if (state !== 2'b10 || ir_valid !== 1'b1) begin fails++; $display("FAIL first_hold got state %h valid %b exp 2/1", state, ir_valid); end
        tests++; if (ir !== 16'hA001 || pc !== 8'h00) begin fails++; $display("FAIL first_ir got ir %h pc %h exp A001/00", ir, pc); end
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        tests++; if (ir_valid !== 1'b0 || pc !== 8'h01 || state !== 2'b01) begin fails++; $display("FAIL ack1 got valid %b pc %h state %h exp 0/01/1", ir_valid, pc, state); end
        tick();
        tests++; if (ir_valid !== 1'b1 || ir !== 16'hB002) begin fails++; $display("FAIL second_ir got valid %b ir %h exp 1/B002", ir_valid, ir); end
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        tests++; if (ir_valid !== 1'b0 || pc !== 8'h02) begin fails++; $display("FAIL ack2 got valid %b pc %h exp 0/02", ir_valid, pc); end
        tick();
        tests++; if (ir_valid !== 1'b1 || ir !== rom[2]) begin fails++; $display("FAIL third_ir got valid %b ir %h exp 1/%h", ir_valid, ir, rom[2]); end
    endtask

    task automatic test_delayed_ack();
        for (int i = 0; i < 5; i++) begin
            ovr_en  = 1'b1;
            ovr_val = 16'hDEAD + 16'(i);
            tick();
            tests++;
            if (ir !== rom[2] || ir_valid !== 1'b1 || pc !== 8'h02 || state !== 2'b10) begin
                fails++;
                $display("FAIL delay_stable[%0d] got ir %h valid %b pc %h state %h exp %h/1/02/2", i, ir, ir_valid, pc, state, rom[2]);
            end
        end
        ovr_en = 1'b0;
        advance();
        advance();
        advance();
        tests++; if (pc !== 8'h05 || ir !== rom[5]) begin fails++; $display("FAIL reach_pc5 got pc %h ir %h exp 05/%h", pc, ir, rom[5]); end
    endtask

    task automatic test_jump();
        ir_ack    = 1'b1;
        jump      = 1'b1;
        jump_addr = 8'h40;
        tick();
        ir_ack    = 1'b0;
        jump      = 1'b0;
        jump_addr = 8'h00;
        tests++; if (pc !== 8'h40 || addr !== 8'h40 || state !== 2'b01) begin fails++; $display("FAIL jump_pc got pc %h addr %h state %h exp 40/40/1", pc, addr, state); end
        tick();
        tests++; if (ir !== 16'h4C40 || ir_valid !== 1'b1) begin fails++; $display("FAIL jump_ir got ir %h valid %b exp 4C40/1", ir, ir_valid); end
        tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL jump_wrap got %b exp 0", wrap); end
    endtask

    task automatic test_wrap();
        ir_ack    = 1'b1;
        jump      = 1'b1;
        jump_addr = 8'hFF;
        tick();
        ir_ack    = 1'b0;
        jump      = 1'b0;
        tick();
        tests++; if (pc !== 8'hFF || ir !== 16'hFFEE || wrap !== 1'b0) begin fails++; $display("FAIL at_ff got pc %h ir %h wrap %b exp FF/FFEE/0", pc, ir, wrap); end
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        tests++; if (pc !== 8'h00 || wrap !== 1'b1) begin fails++; $display("FAIL wrap_set got pc %h wrap %b exp 00/1", pc, wrap); end
        tick();
        tests++; if (ir !== 16'hA001 || wrap !== 1'b1) begin fails++; $display("FAIL wrap_fetch got ir %h wrap %b exp A001/1", ir, wrap); end
        advance();
        tests++; if (pc !== 8'h01 || wrap !== 1'b1) begin fails++; $display("FAIL wrap_sticky got pc %h wrap %b exp 01/1", pc, wrap); end
    endtask

    task automatic test_halt();
        ir_ack    = 1'b1;
        jump      = 1'b1;
        jump_addr = 8'h10;
        tick();
        ir_ack    = 1'b0;
        jump      = 1'b0;
        tick();
        tests++; if (pc !== 8'h10 || ir !== rom[16]) begin fails++; $display("FAIL at_10 got pc %h ir %h exp 10/%h", pc, ir, rom[16]); end
        ir_ack    = 1'b1;
        halt      = 1'b1;
        jump      = 1'b1;
        jump_addr = 8'h77;
        tick();
        halt      = 1'b0;
        tests++; if (state !== 2'b11 || pc !== 8'h10 || ir_valid !== 1'b0) begin fails++; $display("FAIL halt got state %h pc %h valid %b exp 3/10/0", state, pc, ir_valid); end
        tick();
        ir_ack = 1'b0;
        jump   = 1'b0;
        tests++; if (state !== 2'b11 || pc !== 8'h10 || ir !== rom[16] || wrap !== 1'b1) begin fails++; $display("FAIL halted_hold got state %h pc %h ir %h wrap %b exp 3/10/%h/1", state, pc, ir, wrap, rom[16]); end
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++; if (pc !== 8'h00 || wrap !== 1'b0 || state !== 2'b01) begin fails++; $display("FAIL restart got pc %h wrap %b state %h exp 00/0/1", pc, wrap, state); end
        tick();
        tests++; if (ir !== 16'hA001 || ir_valid !== 1'b1) begin fails++; $display("FAIL restart_fetch got ir %h valid %b exp A001/1", ir, ir_valid); end
    endtask

    task automatic test_reset_mid();
        ir_ack    = 1'b1;
        jump      = 1'b1;
        jump_addr = 8'hFF;
        tick();
        jump      = 1'b0;
        ir_ack    = 1'b0;
        tick();
        advance();
        tests++; if (wrap !== 1'b1 || state !== 2'b10 || ir_valid !== 1'b1) begin fails++; $display("FAIL pre_reset got wrap %b state %h valid %b exp 1/2/1", wrap, state, ir_valid); end
        reset     = 1'b1;
        ir_ack    = 1'b1;
        jump      = 1'b1;
        jump_addr = 8'h33;
        tick();
        reset     = 1'b0;
        ir_ack    = 1'b0;
        jump      = 1'b0;
        tests++;
        if (state !== 2'b00 || pc !== 8'h00 || ir !== 16'h0000 || ir_valid !== 1'b0 || wrap !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset got state %h pc %h ir %h valid %b wrap %b exp 0/00/0000/0/0", state, pc, ir, ir_valid, wrap);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b0;
        start     = 1'b0;
        ir_ack    = 1'b0;
        jump      = 1'b0;
        jump_addr = 8'h00;
        halt      = 1'b0;
        ovr_en    = 1'b0;
        ovr_val   = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            rom[i] = {8'h5A, 8'(i)};
        end
        rom[0]   = 16'hA001;
        rom[1]   = 16'hB002;
        rom[64]  = 16'h4C40;
        rom[255] = 16'hFFEE;

        test_reset();
        test_basic_fetch();
        test_delayed_ack();
        test_jump();
        test_wrap();
        test_halt();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction fetch controller for the basic processor. It owns the program counter and drives the address of the 256x16 instruction ROM. That ROM reads combinationally and is loaded from `instructions.txt`. The controller latches each returned word into an instruction register and hands it to the decoder through a valid/ack handshake. It also applies jumps and halt, and flags program-counter wrap-around.

## Interface
Parameters:
- `RESET_PC`, default 8'h00: program counter value after reset and on restart from HALTED.

Ports:
- `clk`, in, 1: single system clock; all state changes on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begins fetching from IDLE, or restarts from HALTED.
- `addr`, out, 8: ROM address; always equals `pc`.
- `r_data`, in, 16: ROM read data, combinational from `addr`.
- `ir`, out, 16: registered instruction word.
- `ir_valid`, out, 1: `ir` holds an instruction not yet acknowledged.
- `ir_ack`, in, 1: decoder consumes `ir`; only meaningful while `ir_valid`=1.
- `jump`, in, 1: with `ir_ack`, load `jump_addr` into `pc`.
- `jump_addr`, in, 8: jump target.
- `halt`, in, 1: with `ir_ack`, stop fetching.
- `pc`, out, 8: current program counter.
- `state`, out, 2: FSM state encoding for debug.
- `wrap`, out, 1: sticky flag; `pc` incremented from 8'hFF to 8'h00.

## Operation
- States and encodings: IDLE=2'b00, FETCH=2'b01, HOLD=2'b10, HALTED=2'b11.
- Reset (`reset`=1 at an edge), overriding all other inputs:
  - state=IDLE, `pc`=RESET_PC, `ir`=16'h0000.
  - `ir_valid`=0, `wrap`=0.
- IDLE:
  - `start`=1 moves to FETCH.
  - Otherwise the controller holds. `pc` is unchanged.
- FETCH (always exactly one cycle):
  - `ir` <= `r_data` (the word at `pc`).
  - `ir_valid` <= 1.
  - Next state is HOLD.
- HOLD:
  - `ir` and `ir_valid`=1 are held until `ir_ack`=1.
  - When `ir_ack`=1, `ir_valid` <= 0. Priority of the remaining actions:
  - `halt`=1: next state HALTED; `pc` unchanged, so it points at the halting instruction. `jump` is ignored.
  - else `jump`=1: `pc` <= `jump_addr`; next state FETCH; `wrap` unaffected.
  - else: `pc` <= `pc`+1 (mod 256); next state FETCH. If `pc` was 8'hFF, `wrap` <= 1.
- HALTED:
  - `ir_valid`=0; `ir` keeps its last value.
  - `start`=1 sets `pc` <= RESET_PC and `wrap` <= 0, then moves to FETCH.
- `jump`, `halt` and `jump_addr` are ignored unless the state is HOLD and `ir_ack`=1.
- `ir_ack` outside HOLD is ignored.
- `start` is ignored in FETCH and HOLD.
- `wrap` clears only on reset or on restart from HALTED.

## Timing
- All outputs are registered. `addr` is a direct copy of the `pc` register, with no combinational path from any input.
- Start latency: `start` sampled at edge n gives state FETCH after n, and `ir_valid`=1 with `ir`=ROM[`pc`] after edge n+1.
- Throughput: at most one instruction per 2 cycles, achieved when `ir_ack` is asserted in the first HOLD cycle.
- Ack to next valid:
  - `ir_ack` at edge n drops `ir_valid` after n.
  - The new `pc` is visible after n.
  - The next `ir_valid`=1 appears after n+1.
- ROM read: `r_data` must settle within one cycle of `addr` changing. It is sampled only in FETCH.
- Reset mid-operation (any state, including HOLD with `ir_ack`=1) takes effect at that edge. The pending ack, jump or halt is discarded.

## Test plan
- Reset, then `start` for 1 cycle, with ROM[0]=16'hA001 and ROM[1]=16'hB002. Ack each instruction in its first HOLD cycle.
  - `ir_valid` rises 2 cycles after `start`.
  - `ir` shows 16'hA001, then 16'hB002.
  - `pc` shows 0, then 1, then 2.
  - `ir_valid` toggles every cycle.
- Delayed ack: hold `ir_ack`=0 for 5 cycles in HOLD.
  - `ir`, `ir_valid`=1 and `pc` remain stable.
  - `r_data` changes during this time are not captured.
- Jump: at `pc`=8'h05, ack with `jump`=1 and `jump_addr`=8'h40.
  - The next fetch has `addr`=8'h40 and `ir`=ROM[0x40].
  - `wrap` stays 0.
- Wrap: `jump` to 8'hFF, then ack with no jump.
  - `pc` becomes 8'h00 and `wrap`=1.
  - `wrap` stays 1 through later fetches until restart.
- Halt with simultaneous `jump`=1 at `pc`=8'h10.
  - state=HALTED, `pc` stays 8'h10, `ir_valid`=0.
  - `start` then gives `pc`=RESET_PC, `wrap`=0, and a fetch of ROM[RESET_PC].
- Reset asserted in HOLD together with `ir_ack`=1 and `jump`=1.
  - After the edge: IDLE, `pc`=RESET_PC, `ir`=0, `ir_valid`=0, `wrap`=0.
